// File: rtl/spi_pwm_host_master.sv
// spi_pwm_host_master
// SPI mode-0 master that turns single-beat level write/read requests into the
// 7-channel SPI PWM driver's byte protocol, and returns a one-cycle response.
// Every SPI phase lasts HALF_PERIOD system clocks so the driver's sclk edge
// detector sees each edge. HALF_PERIOD must be 2 or more.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = write level, 0 = read level
//   req_addr, req_data    channel (7 passed through) and write level
//   rsp_valid, rsp_data   completion pulse; read result (0x00 for writes)
//   sclk, cs, mosi        SPI outputs (sclk idle low, cs active low)
//   miso                  SPI input, same clock domain as the driver
module spi_pwm_host_master #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      bit_q, bit_d;      // 1-based index of the bit on the wire
    logic [23:0]     frame_q, frame_d;  // MSB is the bit currently driven
    logic            write_q, write_d;
    logic [7:0]      cap_q, cap_d;
    logic            rsp_valid_d;
    logic [7:0]      rsp_data_d;

    logic half_done;
    logic last_bit;
    logic capture;

    assign half_done = (cnt_q == CntLast);
    assign last_bit  = (bit_q == (write_q ? 5'd16 : 5'd24));
    // The driver loads the level on fall 9, so rise 10 carries bit 7 and rise 17 bit 0.
    assign capture   = !write_q && (state_q == StHigh) && half_done &&
                       (bit_q >= 5'd10) && (bit_q <= 5'd17);

    assign req_ready = (state_q == StIdle) && !reset;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        write_d     = write_q;
        cap_d       = cap_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;

        if (capture) begin
            cap_d = {cap_q[6:0], miso};
        end
        if (state_q != StIdle) begin
            cnt_d = half_done ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                    write_d = req_write;
                    cap_d   = '0;
                    frame_d = req_write ? {1'b1, 4'b0000, req_addr, req_data, 8'h00}
                                        : {1'b0, 4'b0000, req_addr, 16'h0000};
                end
            end
            StSetup: begin
                if (half_done) begin
                    state_d = StHigh;
                    bit_d   = 5'd1;
                end
            end
            StHigh: begin
                if (half_done) begin
                    state_d = StLow;
                    frame_d = {frame_q[22:0], 1'b0};
                end
            end
            StLow: begin
                if (half_done) begin
                    if (last_bit) begin
                        state_d = StHold;
                    end else begin
                        state_d = StHigh;
                        bit_d   = bit_q + 5'd1;
                    end
                end
            end
            StHold: begin
                if (half_done) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (half_done) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = write_q ? 8'h00 : cap_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // SPI pins are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            write_q   <= 1'b0;
            cap_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            sclk      <= 1'b0;
            cs        <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            write_q   <= write_d;
            cap_q     <= cap_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            sclk      <= (state_d == StHigh);
            cs        <= !(state_d inside {StSetup, StHigh, StLow, StHold});
            mosi      <= (state_d inside {StSetup, StHigh, StLow}) && frame_d[23];
        end
    end

endmodule

// File: tb/tb_spi_pwm_host_master.sv
// Testbench for spi_pwm_host_master: two instances (HALF_PERIOD 4 and 2) share
// the request inputs. Each talks to a behavioural model of the 7-channel PWM
// driver; responses are compared with a plain level-array reference.
module tb_spi_pwm_host_master;

    logic       clk;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic       req_write;
    logic [2:0] req_addr;
    logic [7:0] req_data;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_data [2];
    logic [1:0] sclk;
    logic [1:0] cs;
    logic [1:0] mosi;
    logic [1:0] miso;

    int n_tests;
    int n_fail;
    int cyc;

    spi_pwm_host_master #(.HALF_PERIOD(4)) u_dut_h4 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid[0]),
        .rsp_data  (rsp_data[0]),
        .sclk      (sclk[0]),
        .cs        (cs[0]),
        .mosi      (mosi[0]),
        .miso      (miso[0])
    );

    spi_pwm_host_master #(.HALF_PERIOD(2)) u_dut_h2 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid[1]),
        .rsp_data  (rsp_data[1]),
        .sclk      (sclk[1]),
        .cs        (cs[1]),
        .mosi      (mosi[1]),
        .miso      (miso[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver model (one per DUT), evaluated on falling clk ----
    logic [7:0]  s_lvl     [2][7];
    logic [31:0] s_rx      [2];
    logic [7:0]  s_tx      [2];
    int          s_rises   [2];
    int          s_falls   [2];
    int          s_csrun   [2];
    logic        s_psclk   [2];
    logic        s_pcs     [2];
    logic [31:0] frm_rx    [2][64];
    int          frm_rises [2][64];
    int          frm_gap   [2][64];
    int          frm_cnt   [2];

    initial begin
        logic [7:0] cmd;
        miso = 2'b00;
        for (int g = 0; g < 2; g++) frm_cnt[g] = 0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (reset) begin
                    for (int a = 0; a < 7; a++) s_lvl[g][a] = 8'h00;
                    s_rx[g] = '0; s_tx[g] = '0; s_rises[g] = 0; s_falls[g] = 0;
                    s_csrun[g] = 0; s_psclk[g] = 1'b0; s_pcs[g] = 1'b1; miso[g] = 1'b0;
                end else begin
                    if (cs[g]) begin
                        if (!s_pcs[g]) begin
                            frm_rx[g][frm_cnt[g] % 64]    = s_rx[g];
                            frm_rises[g][frm_cnt[g] % 64] = s_rises[g];
                            frm_cnt[g]++;
                        end
                        s_rises[g] = 0; s_falls[g] = 0; s_tx[g] = '0; miso[g] = 1'b0;
                        s_csrun[g]++;
                    end else begin
                        if (s_pcs[g]) begin
                            frm_gap[g][frm_cnt[g] % 64] = s_csrun[g];
                            s_csrun[g] = 0;
                            s_rx[g] = '0;
                        end
                        if (sclk[g] && !s_psclk[g]) begin
                            s_rx[g] = {s_rx[g][30:0], mosi[g]};
                            s_rises[g]++;
                        end
                        if (!sclk[g] && s_psclk[g]) begin
                            s_falls[g]++;
                            if (s_falls[g] == 9) begin
                                cmd = s_rx[g][8:1];
                                s_tx[g] = (!cmd[7] && cmd[6:3] == 4'd0 && cmd[2:0] != 3'd7)
                                          ? s_lvl[g][cmd[2:0]] : 8'h00;
                            end else begin
                                s_tx[g] = {s_tx[g][6:0], 1'b0};
                            end
                            if (s_falls[g] == 16) begin
                                cmd = s_rx[g][15:8];
                                if (cmd[7] && cmd[6:3] == 4'd0 && cmd[2:0] != 3'd7)
                                    s_lvl[g][cmd[2:0]] = s_rx[g][7:0];
                            end
                            miso[g] = s_tx[g][7];
                        end
                    end
                    s_psclk[g] = sclk[g];
                    s_pcs[g]   = cs[g];
                end
            end
        end
    end

    // ---------------- reference and sequencing --------------------------------
    logic [7:0] ref_lvl [7];
    logic       rq_wr   [2];
    logic [2:0] rq_addr [2];
    logic [7:0] rq_data [2];

    task automatic set_rq(input int k, input logic wr, input logic [2:0] a, input logic [7:0] d);
        rq_wr[k] = wr; rq_addr[k] = a; rq_data[k] = d;
    endtask

    // Runs n (1 or 2) requests back-to-back on both DUTs, then checks them.
    task automatic do_seq(input int n);
        int acc_n [2]; int rsp_n [2]; int base [2];
        int acc_e [2][2]; int rsp_e [2][2]; logic [7:0] rsp_d [2][2];
        bit pend [2];
        int t; int idx; int hp; int nb;
        logic [7:0] exp_d [2]; logic [31:0] exp_f [2]; logic [31:0] mask;
        for (int g = 0; g < 2; g++) begin
            acc_n[g] = 0; rsp_n[g] = 0; pend[g] = 1'b0; base[g] = frm_cnt[g];
            for (int k = 0; k < 2; k++) begin acc_e[g][k] = 0; rsp_e[g][k] = 0; rsp_d[g][k] = 0; end
        end
        t = 0;
        while ((rsp_n[0] < n || rsp_n[1] < n) && t < 2000) begin
            idx = (acc_n[0] < acc_n[1]) ? acc_n[0] : acc_n[1];
            if (idx >= n) begin
                // Junk on the request bus once everything is latched.
                req_write = 1'($urandom); req_addr = 3'($urandom); req_data = 8'($urandom);
            end else begin
                req_write = rq_wr[idx]; req_addr = rq_addr[idx]; req_data = rq_data[idx];
            end
            for (int g = 0; g < 2; g++) begin
                req_valid[g] = (acc_n[g] < n);
                pend[g] = req_valid[g] && req_ready[g];
            end
            @(posedge clk); #1; t++;
            for (int g = 0; g < 2; g++) begin
                if (pend[g]) begin acc_e[g][acc_n[g]] = cyc; acc_n[g]++; end
                if (rsp_valid[g]) begin
                    if (rsp_n[g] < n) begin
                        rsp_e[g][rsp_n[g]] = cyc; rsp_d[g][rsp_n[g]] = rsp_data[g];
                    end
                    rsp_n[g]++;
                end
            end
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) if (rsp_valid[g]) rsp_n[g]++;
        check("seq_done", {31'd0, t < 2000}, 32'd1);

        for (int k = 0; k < n; k++) begin
            if (rq_wr[k]) begin
                exp_d[k] = 8'h00;
                if (rq_addr[k] != 3'd7) ref_lvl[rq_addr[k]] = rq_data[k];
                exp_f[k] = {16'h0000, 1'b1, 4'b0000, rq_addr[k], rq_data[k]};
            end else begin
                exp_d[k] = (rq_addr[k] != 3'd7) ? ref_lvl[rq_addr[k]] : 8'h00;
                exp_f[k] = {8'h00, 1'b0, 4'b0000, rq_addr[k], 16'h0000};
            end
        end
        for (int g = 0; g < 2; g++) begin
            hp = (g == 0) ? 4 : 2;
            check($sformatf("h%0d rsp_pulses", hp), rsp_n[g], n);
            check($sformatf("h%0d rsp_hold", hp), rsp_data[g], rsp_d[g][n-1]);
            for (int k = 0; k < n; k++) begin
                nb   = rq_wr[k] ? 16 : 24;
                mask = (nb == 16) ? 32'h0000_FFFF : 32'h00FF_FFFF;
                check($sformatf("h%0d latency", hp), rsp_e[g][k] - acc_e[g][k], (2 * nb + 3) * hp);
                check($sformatf("h%0d rsp_data a%0d", hp, rq_addr[k]), rsp_d[g][k], exp_d[k]);
                check($sformatf("h%0d rises", hp), frm_rises[g][(base[g] + k) % 64], nb);
                check($sformatf("h%0d mosi_frame", hp), frm_rx[g][(base[g] + k) % 64] & mask,
                      exp_f[k]);
                if (k > 0) begin
                    check($sformatf("h%0d b2b_accept", hp), acc_e[g][k], rsp_e[g][k-1] + 1);
                    check($sformatf("h%0d cs_gap", hp), frm_gap[g][(base[g] + k) % 64], hp + 1);
                end
            end
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) begin
            set_rq(0, 1'b0, 3'(a), 8'h00);
            do_seq(1);
        end
    endtask

    initial begin
        int t;
        int hits;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; req_valid = 2'b00; req_write = 1'b0; req_addr = 3'd0; req_data = 8'h00;
        for (int a = 0; a < 7; a++) ref_lvl[a] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", req_ready, 2'b00);
        reset = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst cs%0d", g), cs[g], 1'b1);
            check($sformatf("rst sclk%0d", g), sclk[g], 1'b0);
            check($sformatf("rst mosi%0d", g), mosi[g], 1'b0);
            check($sformatf("rst rsp_valid%0d", g), rsp_valid[g], 1'b0);
            check($sformatf("rst rsp_data%0d", g), rsp_data[g], 8'h00);
            check($sformatf("rst ready%0d", g), req_ready[g], 1'b1);
        end
        @(posedge clk); #1;

        // Write then read back channel 3.
        set_rq(0, 1'b1, 3'd3, 8'hA5); do_seq(1);
        set_rq(0, 1'b0, 3'd3, 8'h00); do_seq(1);
        // Address 7 is passed through and ignored by the driver.
        set_rq(0, 1'b1, 3'd7, 8'hFF); do_seq(1);
        set_rq(0, 1'b0, 3'd7, 8'h00); do_seq(1);
        read_all();
        // Back-to-back writes with req_valid held high.
        set_rq(0, 1'b1, 3'd0, 8'h01); set_rq(1, 1'b1, 3'd6, 8'hFE); do_seq(2);
        set_rq(0, 1'b0, 3'd0, 8'h00); set_rq(1, 1'b0, 3'd6, 8'h00); do_seq(2);
        // H=2 boundary write/read of ch5 is covered on the second instance.
        set_rq(0, 1'b1, 3'd5, 8'h3C); do_seq(1);
        set_rq(0, 1'b0, 3'd5, 8'h00); do_seq(1);

        // Reset during a write, after rise 12 on the H=4 instance.
        req_write = 1'b1; req_addr = 3'd2; req_data = 8'h55; req_valid = 2'b11;
        @(posedge clk); #1;
        req_valid = 2'b00;
        t = 0;
        while (s_rises[0] < 12 && t < 1000) begin @(posedge clk); #1; t++; end
        check("rst_mid_wait", {31'd0, t < 1000}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid ready_low", req_ready, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_mid cs", cs[0], 1'b1);
        check("rst_mid sclk", sclk[0], 1'b0);
        check("rst_mid mosi", mosi[0], 1'b0);
        check("rst_mid ready", req_ready, 2'b11);
        for (int a = 0; a < 7; a++) ref_lvl[a] = 8'h00;
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) hits++;
        end
        check("rst_mid no_rsp", hits, 0);
        set_rq(0, 1'b0, 3'd2, 8'h00); do_seq(1);

        // Randomized traffic against the level-array reference.
        for (int i = 0; i < 24; i++) begin
            set_rq(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            do_seq(1);
        end
        set_rq(0, 1'b1, 3'($urandom_range(0, 6)), 8'($urandom));
        set_rq(1, 1'b1, 3'($urandom_range(0, 6)), 8'($urandom));
        do_seq(2);
        read_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_pwm_host_master.md
# spi_pwm_host_master

SPI master that programs and reads back the 7-channel SPI PWM driver from on-chip logic. It converts a single-beat request (write level / read level for one channel) into the driver's byte protocol on `sclk`/`cs`/`mosi`, captures `miso`, and returns a one-cycle response. It shares the driver's system clock and paces every SPI edge so the driver sees it through its `sclk` edge detector.

## Interface
- `HALF_PERIOD`, default 4: system-clock cycles per `sclk` half-period. The legal minimum is 2; values below 2 are illegal.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle, can accept a request.
- `req_write` in 1: 1 = write level, 0 = read level.
- `req_addr` in 3: channel 0..6; 7 is passed through unchanged.
- `req_data` in 8: level for writes; ignored for reads.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: read result; 0x00 for writes.
- `sclk` out 1: SPI clock, idle low (mode 0).
- `cs` out 1: chip select, active low, idle high.
- `mosi` out 1: MSB-first data to the driver.
- `miso` in 1: data from the driver, same clock domain, no synchronizer.

## Operation
- **Reset values:** `cs`=1, `sclk`=0, `mosi`=0, `req_ready`=0 during reset and 1 after, `rsp_valid`=0, `rsp_data`=0x00, FSM in IDLE.
- **Accept:** a request is accepted on an edge where `req_valid && req_ready`. The block latches the frame and the bit count N.
  - Write frame: `{1'b1, 4'b0, addr}`, then `req_data`; N=16.
  - Read frame: `{1'b0, 4'b0, addr}`, then 0x00, then 0x00; N=24.
- **FSM states:** IDLE → SETUP → HIGH ⇄ LOW → HOLD → GAP → IDLE. Each non-IDLE state lasts exactly H=`HALF_PERIOD` cycles.
- **SETUP:** `cs`=0, `sclk`=0, `mosi`=frame MSB.
- **HIGH:** `sclk`=1, `mosi` unchanged.
  - For reads, `miso` is sampled in the last cycle of HIGH for rising edges k=10..17 (1-based).
  - These 8 samples shift MSB-first into the capture register. The driver loads its level on falling edge 9 and shifts on each later fall, so rise 10 carries bit 7 and rise 17 carries bit 0.
- **LOW:** `sclk`=0.
  - On entry, `mosi` advances to the next frame bit.
  - After the LOW of bit N, go to HOLD; otherwise go to HIGH.
  - The trailing fall after a write's 16th rise is the one that commits the level in the driver.
- **HOLD:** `cs`=0, `sclk`=0, `mosi`=0.
- **GAP:** `cs`=1. The driver clears its SPI state while `cs` is high.
- **Completion:** in the cycle GAP ends, the FSM enters IDLE and asserts `rsp_valid` for one cycle.
  - `rsp_data` = capture register for reads, 0x00 for writes.
  - `rsp_data` holds until the next `rsp_valid`.
  - `req_ready`=1 in that same cycle, so a back-to-back request can be accepted there.
- **Boundary conditions:**
  - Address 7 is sent as-is: the driver ignores the write, and a read returns 0x00.
  - `req_*` are ignored while not ready.
  - Reset mid-transfer aborts immediately: `cs`=1 on the next cycle and no `rsp_valid` is produced. The driver discards the partial frame.

## Timing
- With acceptance at edge E0, `cs` falls after E0, and `rsp_valid` is high in the cycle beginning at edge E0+(2N+3)·H.
  - Write, H=4: 140 cycles.
  - Read, H=4: 204 cycles.
- `sclk` period is 2H cycles with 50 % duty.
- `mosi` is stable at least H cycles before and after each rising `sclk`.
- `cs` setup to the first rise is H cycles. `cs` hold after the last fall is H cycles. Minimum `cs`-high between frames is H+1 cycles.

## Test plan
- **Write:** H=4, write addr 3 = 0xA5 → `mosi` bytes 0x83, 0xA5; 16 rises; `rsp_valid` at E0+140 with `rsp_data`=0x00; driver channel 3 level = 0xA5; PWM output 3 high for 165 of 255 cycles.
- **Read-back:** read addr 3 after the write → 24 rises, `mosi` 0x03,0x00,0x00; `rsp_valid` at E0+204 with `rsp_data`=0xA5.
- **Invalid address:** write addr 7 = 0xFF, then read addr 7 → `rsp_data`=0x00; channels 0–6 unchanged.
- **Back-to-back:** hold `req_valid` high with two writes (ch0=0x01, ch6=0xFE) → second accepted in the first's `rsp_valid` cycle; `cs` high for exactly H+1 cycles between frames; both levels land.
- **Reset mid-transfer:** assert `reset` for 1 cycle after rise 12 of a write (ch2=0x55) → `cs`=1, `sclk`=0, `mosi`=0 next cycle; no `rsp_valid`; `req_ready`=1 after reset; a subsequent read of ch2 returns 0x00, since the driver was also reset.
- **Minimum H:** H=2, write then read ch5=0x3C → read returns 0x3C; `rsp_valid` at E0+70 (write) and E0+102 (read).
